// File: rtl/wfa_pkg.sv
// Shared widths, diagonal-entry layout and extend FSM encoding for the
// wavefront extend/reduce pipeline.
package wfa_pkg;
    localparam int NUM_EXTEND    = 8;
    localparam int EXTEND_LEN    = 8;
    localparam int TILE_SIZE     = 512;
    localparam int LOG_TILE_SIZE = $clog2(TILE_SIZE);
    localparam int TB_ADDR       = 10;
    localparam int CHAR_WIDTH    = 2;
    localparam int FIFO_WIDTH    = 2*LOG_TILE_SIZE + TB_ADDR + 2;

    localparam int LEN_WIDTH     = LOG_TILE_SIZE + 1;
    localparam int REM_WIDTH     = LOG_TILE_SIZE + 2;
    localparam int CNT_WIDTH     = $clog2(EXTEND_LEN) + 1;
    localparam int LANE_CHARS_W  = EXTEND_LEN * CHAR_WIDTH;

    // Bit positions of each field inside one packed entry
    localparam int TBADDR_LSB    = 0;
    localparam int OFFSET_LSB    = TB_ADDR;
    localparam int K_LSB         = TB_ADDR + LOG_TILE_SIZE;
    localparam int VALID_BIT     = FIFO_WIDTH - 1;

    typedef struct packed {
        logic                       valid;
        logic [LOG_TILE_SIZE:0]     k;       // two's complement diagonal
        logic [LOG_TILE_SIZE-1:0]   offset;
        logic [TB_ADDR-1:0]         tbaddr;
    } diag_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_HOLD    = 2'd3
    } ext_state_t;
endpackage

// File: rtl/match_count.sv
// Per-lane extension length: leading matching characters, clipped by the
// remaining ref/query tile lengths and by EXTEND_LEN.
module match_count
    import wfa_pkg::*;
(
    input  logic [LANE_CHARS_W-1:0] ref_chars_i,
    input  logic [LANE_CHARS_W-1:0] qry_chars_i,
    input  logic [REM_WIDTH-1:0]    rem_r_i,
    input  logic [REM_WIDTH-1:0]    rem_q_i,
    output logic [CNT_WIDTH-1:0]    cnt_o
);
    logic [EXTEND_LEN-1:0] mismatch;
    logic [CNT_WIDTH-1:0]  match_len;
    logic [CNT_WIDTH-1:0]  lim_r;
    logic [CNT_WIDTH-1:0]  lim_q;
    logic [CNT_WIDTH-1:0]  lim;

    for (genvar gi = 0; gi < EXTEND_LEN; gi++) begin : g_cmp
        assign mismatch[gi] = ref_chars_i[gi*CHAR_WIDTH +: CHAR_WIDTH]
                           != qry_chars_i[gi*CHAR_WIDTH +: CHAR_WIDTH];
    end

    // Lowest mismatching index wins; no mismatch means a full-length match
    always_comb begin
        match_len = CNT_WIDTH'(EXTEND_LEN);
        for (int j = EXTEND_LEN - 1; j >= 0; j--) begin
            if (mismatch[j]) begin
                match_len = CNT_WIDTH'(j);
            end
        end
    end

    function automatic logic [CNT_WIDTH-1:0] clamp(input logic [REM_WIDTH-1:0] rem);
        if (rem[REM_WIDTH-1]) begin
            return '0;
        end
        if (rem >= REM_WIDTH'(EXTEND_LEN)) begin
            return CNT_WIDTH'(EXTEND_LEN);
        end
        return rem[CNT_WIDTH-1:0];
    endfunction

    assign lim_r = clamp(rem_r_i);
    assign lim_q = clamp(rem_q_i);
    assign lim   = (lim_r < lim_q) ? lim_r : lim_q;
    assign cnt_o = (match_len < lim) ? match_len : lim;
endmodule

// File: rtl/extend_group.sv
// Extends a group of wavefront diagonals by repeated ref/query buffer reads
// and hands the finished group to the reduce stage.
module extend_group
    import wfa_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                new_score,
    input  logic [LEN_WIDTH-1:0]                ref_len,
    input  logic [LEN_WIDTH-1:0]                qry_len,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FIFO_WIDTH*NUM_EXTEND-1:0]    in_data,
    output logic [LOG_TILE_SIZE*NUM_EXTEND-1:0] ref_addr,
    output logic [LOG_TILE_SIZE*NUM_EXTEND-1:0] qry_addr,
    input  logic [LANE_CHARS_W*NUM_EXTEND-1:0]  ref_data,
    input  logic [LANE_CHARS_W*NUM_EXTEND-1:0]  qry_data,
    output logic [NUM_EXTEND-1:0]               red_valid,
    output logic [FIFO_WIDTH*NUM_EXTEND-1:0]    red_offset,
    input  logic                                red_read
);
    ext_state_t                                    state_q, state_d;
    diag_entry_t [NUM_EXTEND-1:0]                  group_q, group_d;
    logic [NUM_EXTEND-1:0]                         lane_done_q, lane_done_d;
    logic [NUM_EXTEND-1:0][LOG_TILE_SIZE-1:0]      ref_addr_q, ref_addr_d;
    logic [NUM_EXTEND-1:0][LOG_TILE_SIZE-1:0]      qry_addr_q, qry_addr_d;
    logic                                          red_valid_q, red_valid_d;
    logic [NUM_EXTEND-1:0][CNT_WIDTH-1:0]          lane_cnt;

    for (genvar gi = 0; gi < NUM_EXTEND; gi++) begin : g_lane
        logic [REM_WIDTH-1:0] diag_pos;
        logic [REM_WIDTH-1:0] rem_r;
        logic [REM_WIDTH-1:0] rem_q;

        // Query position is offset - k, with k sign-extended
        assign diag_pos = {2'b00, group_q[gi].offset}
                        - {group_q[gi].k[LOG_TILE_SIZE], group_q[gi].k};
        assign rem_r    = {1'b0, ref_len} - {2'b00, group_q[gi].offset};
        assign rem_q    = {1'b0, qry_len} - diag_pos;

        match_count u_match (
            .ref_chars_i (ref_data[gi*LANE_CHARS_W +: LANE_CHARS_W]),
            .qry_chars_i (qry_data[gi*LANE_CHARS_W +: LANE_CHARS_W]),
            .rem_r_i     (rem_r),
            .rem_q_i     (rem_q),
            .cnt_o       (lane_cnt[gi])
        );
    end

    always_comb begin
        state_d     = state_q;
        group_d     = group_q;
        lane_done_d = lane_done_q;
        red_valid_d = red_valid_q;
        ref_addr_d  = ref_addr_q;
        qry_addr_d  = qry_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    group_d = in_data;
                    for (int i = 0; i < NUM_EXTEND; i++) begin
                        lane_done_d[i] = !group_d[i].valid;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                for (int i = 0; i < NUM_EXTEND; i++) begin
                    if (!lane_done_q[i]) begin
                        group_d[i].offset = group_q[i].offset
                            + {{(LOG_TILE_SIZE-CNT_WIDTH){1'b0}}, lane_cnt[i]};
                        lane_done_d[i] = lane_cnt[i] < CNT_WIDTH'(EXTEND_LEN);
                    end
                end
                if (&lane_done_d) begin
                    state_d     = ST_HOLD;
                    red_valid_d = 1'b1;
                end else begin
                    state_d     = ST_ISSUE;
                end
            end
            ST_HOLD: begin
                if (red_read) begin
                    red_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_score) begin
            state_d     = ST_IDLE;
            red_valid_d = 1'b0;
            group_d     = '0;
            lane_done_d = '0;
        end

        // Addresses are loaded on entry to ISSUE and held through COMPARE
        if (state_d == ST_ISSUE) begin
            for (int i = 0; i < NUM_EXTEND; i++) begin
                ref_addr_d[i] = group_d[i].offset;
                qry_addr_d[i] = group_d[i].offset - group_d[i].k[LOG_TILE_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            group_q     <= '0;
            lane_done_q <= '0;
            red_valid_q <= 1'b0;
            ref_addr_q  <= '0;
            qry_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            group_q     <= group_d;
            lane_done_q <= lane_done_d;
            red_valid_q <= red_valid_d;
            ref_addr_q  <= ref_addr_d;
            qry_addr_q  <= qry_addr_d;
        end
    end

    // Holding off while red_read is high stops reduce consuming a group twice
    assign in_ready   = rst && (state_q == ST_IDLE) && !red_read;
    assign red_valid  = {NUM_EXTEND{red_valid_q}};
    assign red_offset = group_q;
    assign ref_addr   = ref_addr_q;
    assign qry_addr   = qry_addr_q;
endmodule

// File: tb/tb_extend_group.sv
// Directed bench for extend_group with a one-cycle-latency ref/query buffer model.
module tb_extend_group;
    import wfa_pkg::*;

    localparam int GW = FIFO_WIDTH * NUM_EXTEND;

    logic                                clk = 1'b0;
    logic                                rst = 1'b0;
    logic                                new_score = 1'b0;
    logic [LEN_WIDTH-1:0]                ref_len = '0;
    logic [LEN_WIDTH-1:0]                qry_len = '0;
    logic                                in_valid = 1'b0;
    logic                                in_ready;
    logic [GW-1:0]                       in_data = '0;
    logic [LOG_TILE_SIZE*NUM_EXTEND-1:0] ref_addr;
    logic [LOG_TILE_SIZE*NUM_EXTEND-1:0] qry_addr;
    logic [LANE_CHARS_W*NUM_EXTEND-1:0]  ref_data;
    logic [LANE_CHARS_W*NUM_EXTEND-1:0]  qry_data;
    logic [NUM_EXTEND-1:0]               red_valid;
    logic [GW-1:0]                       red_offset;
    logic                                red_read = 1'b0;

    logic [CHAR_WIDTH-1:0] ref_mem [TILE_SIZE];
    logic [CHAR_WIDTH-1:0] qry_mem [TILE_SIZE];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    extend_group dut (
        .clk        (clk),
        .rst        (rst),
        .new_score  (new_score),
        .ref_len    (ref_len),
        .qry_len    (qry_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ref_addr   (ref_addr),
        .qry_addr   (qry_addr),
        .ref_data   (ref_data),
        .qry_data   (qry_data),
        .red_valid  (red_valid),
        .red_offset (red_offset),
        .red_read   (red_read)
    );

    // Buffer model: char j of a lane is mem[addr+j], one cycle after the address
    always @(posedge clk) begin
        for (int l = 0; l < NUM_EXTEND; l++) begin
            for (int j = 0; j < EXTEND_LEN; j++) begin
                ref_data[(l*EXTEND_LEN+j)*CHAR_WIDTH +: CHAR_WIDTH] <=
                    ref_mem[LOG_TILE_SIZE'(ref_addr[l*LOG_TILE_SIZE +: LOG_TILE_SIZE] + LOG_TILE_SIZE'(j))];
                qry_data[(l*EXTEND_LEN+j)*CHAR_WIDTH +: CHAR_WIDTH] <=
                    qry_mem[LOG_TILE_SIZE'(qry_addr[l*LOG_TILE_SIZE +: LOG_TILE_SIZE] + LOG_TILE_SIZE'(j))];
            end
        end
    end

    function automatic logic [FIFO_WIDTH-1:0] ent(input logic v, input int k, input int off, input int tb);
        logic [FIFO_WIDTH-1:0] e;
        e = '0;
        e[VALID_BIT]                   = v;
        e[K_LSB +: LEN_WIDTH]          = k[LEN_WIDTH-1:0];
        e[OFFSET_LSB +: LOG_TILE_SIZE] = off[LOG_TILE_SIZE-1:0];
        e[TBADDR_LSB +: TB_ADDR]       = tb[TB_ADDR-1:0];
        return e;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < TILE_SIZE; i++) begin
            ref_mem[i] = CHAR_WIDTH'((i*5 + i/7) % 4);
            qry_mem[i] = ref_mem[i];
        end
    endtask

    task automatic send_group(input logic [GW-1:0] data);
        in_data  = data;
        in_valid = 1'b1;
        for (int w = 0; w < 50 && !in_ready; w++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until red_valid is seen (2N for N iterations)
    task automatic wait_hold(output int n);
        n = 0;
        while (n < 100 && red_valid[0] !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        if (red_valid[0] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_hold: red_valid=%b after %0d cycles", red_valid, n);
        end
    endtask

    task automatic release_hold();
        red_read = 1'b1;
        @(posedge clk); #1;
        red_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++;
        if (red_valid !== '0) begin errors++; $display("FAIL reset_red_valid: got %h required 0", red_valid); end
        checks++;
        if (red_offset !== '0) begin errors++; $display("FAIL reset_red_offset: got %h required 0", red_offset); end
        checks++;
        if (ref_addr !== '0 || qry_addr !== '0) begin
            errors++; $display("FAIL reset_addr: ref %h qry %h required 0", ref_addr, qry_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_full_match();
        logic [GW-1:0] grp, exp;
        int n;
        fill_mem();
        qry_mem[30] = ~ref_mem[30];
        ref_len = 10'd100; qry_len = 10'd100;
        grp = '0;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 10, 'h155);
        exp = grp;
        exp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 30, 'h155);
        send_group(grp);
        wait_hold(n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL full_match_latency: got %0d required 6", n); end
        checks++;
        if (red_offset !== exp) begin errors++; $display("FAIL full_match_group: got %h required %h", red_offset, exp); end
        checks++;
        if (red_valid !== {NUM_EXTEND{1'b1}}) begin errors++; $display("FAIL full_match_valid: got %b", red_valid); end
        release_hold();
    endtask

    task automatic test_immediate_mismatch();
        logic [GW-1:0] grp;
        int n;
        fill_mem();
        qry_mem[50] = ~ref_mem[50];
        grp = '0;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 50, 3);
        send_group(grp);
        wait_hold(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL mismatch_latency: got %0d required 2", n); end
        checks++;
        if (red_offset !== grp) begin errors++; $display("FAIL mismatch_group: got %h required %h", red_offset, grp); end
        release_hold();
    endtask

    task automatic test_end_clip();
        logic [GW-1:0] grp, exp;
        int n;
        fill_mem();
        ref_len = 10'd13; qry_len = 10'd100;
        grp = '0;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 10, 7);
        exp = '0;
        exp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 13, 7);
        send_group(grp);
        wait_hold(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL clip_ref_latency: got %0d required 2", n); end
        checks++;
        if (red_offset !== exp) begin errors++; $display("FAIL clip_ref_group: got %h required %h", red_offset, exp); end
        release_hold();

        for (int i = 0; i < TILE_SIZE - 2; i++) qry_mem[i] = ref_mem[i+2];
        ref_len = 10'd100; qry_len = 10'd9;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 2, 10, 7);
        exp[0 +: FIFO_WIDTH] = ent(1'b1, 2, 11, 7);
        send_group(grp);
        wait_hold(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL clip_qry_latency: got %0d required 2", n); end
        checks++;
        if (red_offset !== exp) begin errors++; $display("FAIL clip_qry_group: got %h required %h", red_offset, exp); end
        release_hold();
    endtask

    task automatic test_multi_lane();
        logic [GW-1:0] grp, exp;
        int n;
        fill_mem();
        qry_mem[45] = ~ref_mem[45];
        for (int p = 200; p <= 230; p++) qry_mem[p+3] = ref_mem[p];
        qry_mem[214] = ~ref_mem[211];
        ref_len = 10'd500; qry_len = 10'd500;
        grp = '0;
        grp[0*FIFO_WIDTH +: FIFO_WIDTH] = ent(1'b1, 0, 40, 11);
        grp[2*FIFO_WIDTH +: FIFO_WIDTH] = ent(1'b1, -3, 200, 22);
        exp = grp;
        exp[0*FIFO_WIDTH +: FIFO_WIDTH] = ent(1'b1, 0, 45, 11);
        exp[2*FIFO_WIDTH +: FIFO_WIDTH] = ent(1'b1, -3, 211, 22);
        send_group(grp);
        checks++;
        if (ref_addr[2*LOG_TILE_SIZE +: LOG_TILE_SIZE] !== LOG_TILE_SIZE'(200)) begin
            errors++; $display("FAIL issue_ref_addr: got %0d required 200", ref_addr[2*LOG_TILE_SIZE +: LOG_TILE_SIZE]);
        end
        checks++;
        if (qry_addr[2*LOG_TILE_SIZE +: LOG_TILE_SIZE] !== LOG_TILE_SIZE'(203)) begin
            errors++; $display("FAIL issue_qry_addr: got %0d required 203", qry_addr[2*LOG_TILE_SIZE +: LOG_TILE_SIZE]);
        end
        wait_hold(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL multi_latency: got %0d required 4", n); end
        checks++;
        if (red_offset !== exp) begin errors++; $display("FAIL multi_group: got %h required %h", red_offset, exp); end
        release_hold();
    endtask

    task automatic test_invalid_lanes();
        logic [GW-1:0] grp, exp;
        int n;
        fill_mem();
        qry_mem[76] = ~ref_mem[76];
        ref_len = 10'd300; qry_len = 10'd300;
        grp = '0;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 60, 5);
        for (int l = 1; l < NUM_EXTEND; l++)
            grp[l*FIFO_WIDTH +: FIFO_WIDTH] = ent(1'b0, int'($urandom_range(1023)), int'($urandom_range(511)), int'($urandom_range(1023)));
        exp = grp;
        exp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 76, 5);
        send_group(grp);
        wait_hold(n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL invalid_latency: got %0d required 6", n); end
        checks++;
        if (red_offset !== exp) begin errors++; $display("FAIL invalid_group: got %h required %h", red_offset, exp); end
        release_hold();

        for (int l = 0; l < NUM_EXTEND; l++)
            grp[l*FIFO_WIDTH +: FIFO_WIDTH] = ent(1'b0, int'($urandom_range(1023)), int'($urandom_range(511)), int'($urandom_range(1023)));
        send_group(grp);
        wait_hold(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL all_invalid_latency: got %0d required 2", n); end
        checks++;
        if (red_offset !== grp) begin errors++; $display("FAIL all_invalid_group: got %h required %h", red_offset, grp); end
        release_hold();
    endtask

    task automatic test_handshake();
        logic [GW-1:0] grp, exp;
        int n;
        bit rose;
        fill_mem();
        qry_mem[103] = ~ref_mem[103];
        ref_len = 10'd300; qry_len = 10'd300;
        grp = '0;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 100, 9);
        exp = grp;
        exp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 103, 9);
        send_group(grp);
        wait_hold(n);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (red_valid !== {NUM_EXTEND{1'b1}} || red_offset !== exp) begin
                errors++; $display("FAIL hold_stable[%0d]: valid %b group %h required %h", c, red_valid, red_offset, exp);
            end
        end
        red_read = 1'b1;
        in_data  = grp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (red_valid !== '0) begin errors++; $display("FAIL read_clears_valid: got %b required 0", red_valid); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_while_read[%0d]: got %b required 0", c, in_ready); end
            @(posedge clk); #1;
        end
        red_read = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_read: got %b required 1", in_ready); end
        rose = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (red_valid !== '0) rose = 1'b1;
        end
        checks++;
        if (rose) begin errors++; $display("FAIL no_double_accept: red_valid rose=%b required 0", rose); end
    endtask

    task automatic test_flush();
        logic [GW-1:0] grp;
        bit rose;
        fill_mem();
        qry_mem[30] = ~ref_mem[30];
        ref_len = 10'd100; qry_len = 10'd100;
        grp = '0;
        grp[0 +: FIFO_WIDTH] = ent(1'b1, 0, 10, 1);
        send_group(grp);
        @(posedge clk); #1;
        new_score = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (red_valid !== '0) begin errors++; $display("FAIL flush_valid: got %b required 0", red_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b required 1", in_ready); end
        new_score = 1'b0;
        rose = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (red_valid !== '0) rose = 1'b1;
        end
        checks++;
        if (rose) begin errors++; $display("FAIL flush_no_partial: rose=%b required 0", rose); end

        send_group(grp);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || red_valid !== '0) begin
            errors++; $display("FAIL midreset_state: in_ready %b red_valid %b required 0 0", in_ready, red_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", in_ready); end
        rose = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (red_valid !== '0) rose = 1'b1;
        end
        checks++;
        if (rose) begin errors++; $display("FAIL midreset_no_partial: rose=%b required 0", rose); end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_full_match();
        test_immediate_mismatch();
        test_end_clip();
        test_multi_lane();
        test_invalid_lanes();
        test_handshake();
        test_flush();
        test_full_match();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/extend_group.md
# extend_group

Extend stage for a group of NUM_EXTEND wavefront diagonals. It accepts one packed group of {valid, k, offset, tbaddr} entries and issues per-lane ref/query buffer reads, EXTEND_LEN characters per iteration. Each lane's offset advances along its diagonal until a mismatch or the end of the tile. The finished group is then presented to the reduce stage over the ext2red handshake. It sits between the wavefront FIFO and reduce.

## Interface
- NUM_EXTEND, 8, lanes per group
- EXTEND_LEN, 8, characters compared per lane per iteration
- TILE_SIZE, 512, tile length; LOG_TILE_SIZE = $clog2(TILE_SIZE)
- TB_ADDR, 10, traceback address width
- CHAR_WIDTH, 2, bits per base
- FIFO_WIDTH, 2*LOG_TILE_SIZE+TB_ADDR+2, entry width
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- new_score  in  1  synchronous flush to IDLE
- ref_len, qry_len  in  LOG_TILE_SIZE+1 each  tile lengths (chars)
- in_valid  in  1  group available
- in_ready  out  1  group accepted when in_valid&in_ready
- in_data  in  FIFO_WIDTH*NUM_EXTEND  lane i at bits [(i+1)*FIFO_WIDTH-1 : i*FIFO_WIDTH], packed {valid, k (two's complement, LOG_TILE_SIZE+1), offset (LOG_TILE_SIZE), tbaddr}
- ref_addr, qry_addr  out  LOG_TILE_SIZE*NUM_EXTEND  per-lane read addresses
- ref_data, qry_data  in  EXTEND_LEN*CHAR_WIDTH*NUM_EXTEND  per lane: char j = mem[addr+j] in bits [(j+1)*CHAR_WIDTH-1 : j*CHAR_WIDTH]; one-cycle read latency
- red_valid  out  NUM_EXTEND  all bits assert and deassert together
- red_offset  out  FIFO_WIDTH*NUM_EXTEND  extended group, same packing as in_data
- red_read  in  1  consumer acknowledge

## Operation
- States: IDLE, ISSUE, COMPARE, HOLD.
- IDLE:
  - in_ready=1.
  - On accept: latch in_data, set lane_done[i] = !valid[i], go to ISSUE.
- ISSUE:
  - ref_addr[i] = offset[i].
  - qry_addr[i] = offset[i]-k[i], truncated to LOG_TILE_SIZE.
  - Go to COMPARE.
- COMPARE, for each lane with !lane_done:
  - m = leading matching characters, counted from char 0.
  - rem_r = ref_len-offset; rem_q = qry_len-(offset-k). Both non-negative by construction; compute in LOG_TILE_SIZE+2 bits.
  - cnt = min(m, rem_r, rem_q, EXTEND_LEN).
  - offset += cnt.
  - lane_done set iff cnt < EXTEND_LEN.
  - k, tbaddr and valid are never modified.
  - If all lanes are done, go to HOLD; else go to ISSUE.
- At least one ISSUE/COMPARE iteration runs per group, even when every lane is invalid.
- HOLD:
  - red_valid all ones; red_offset = latched group.
  - When red_read is sampled 1: clear red_valid, go to IDLE.
- A new group is not accepted while red_read=1. Because reduce leaves read asserted, this prevents double consumption.
- new_score=1 in any state: next state IDLE, red_valid=0, latched group discarded. new_score has priority over every other transition.

## Timing
- Reset values (rst=0):
  - state IDLE.
  - in_ready 0 during reset, 1 the cycle after.
  - red_valid 0, red_offset 0.
  - ref_addr, qry_addr 0.
  - lane_done 0.
- Group accepted at cycle T. ISSUE at T+1; read data is valid in COMPARE.
  - After N iterations, red_valid rises at T+1+2N.
- Addresses are registered outputs, stable for the whole of ISSUE and COMPARE.
- red_offset and red_valid are stable throughout HOLD.
- in_ready is combinational: (state==IDLE) & !red_read.
- Reset mid-operation or new_score mid-operation: state returns to IDLE in the next cycle, and no partial group is ever presented.

## Structure
- Shared package `wfa_pkg`:
  - FIFO_WIDTH and the entry-field slice localparams.
  - Typedef `diag_entry_t` (packed {valid, k, offset, tbaddr}).
  - CHAR_WIDTH.
- One sub-module, `match_count`: combinational, per lane.
  - Inputs: ref chars, qry chars, rem_r, rem_q.
  - Output: cnt, built from a priority encoder over the mismatch vector.
  - Instantiate NUM_EXTEND times in a generate loop.

## Test plan
- Full match, then mismatch: lane0 k=0, offset=10, ref==qry for 20 chars then differ, lens 100.
  - Required: 3 iterations (8,8,4), red_offset lane0 offset=30, red_valid at T+7.
- Immediate mismatch: char 0 differs.
  - Required: offset unchanged, red_valid at T+3.
- End clip: ref_len=13, offset=10, all chars match.
  - Required: offset=13, one iteration.
  - Repeat with k=2, qry_len=9 (rem_q=1): offset=11.
- Invalid lanes: lanes 1-7 valid=0 and lane0 matches 16 chars.
  - Required: invalid lanes returned bit-identical; 3 iterations.
  - All-invalid group: red_valid at T+3.
- Handshake:
  - red_read low for 5 cycles in HOLD: outputs stable.
  - red_read high: red_valid 0 next cycle.
  - in_ready stays 0 until red_read drops.
- new_score asserted during COMPARE: IDLE next cycle, red_valid 0, in_ready 1.
  - Repeat with rst low mid-ISSUE: same result after reset.
